// File: rtl/tuser_in_fsm.sv
// AXIS ingress stage ahead of the SDNet engine: two-slot skid buffer for packet
// beats plus capture of the first-beat tuser as the engine's input tuple.
module tuser_in_fsm #(
  parameter int DATA_W  = 256,
  parameter int KEEP_W  = 32,
  parameter int TUSER_W = 128,
  parameter int CNT_W   = 32
) (
  input  logic               tin_aclk,
  input  logic               tin_arst,
  input  logic               tin_avalid,
  output logic               tin_aready,
  input  logic [DATA_W-1:0]  tin_adata,
  input  logic [KEEP_W-1:0]  tin_akeep,
  input  logic               tin_atlast,
  input  logic [TUSER_W-1:0] tin_atuser,
  output logic               tin_bvalid,
  input  logic               tin_bready,
  output logic [DATA_W-1:0]  tin_bdata,
  output logic [KEEP_W-1:0]  tin_bkeep,
  output logic               tin_btlast,
  output logic               tin_valid,
  output logic [TUSER_W-1:0] tin_data,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] BODY = 3'b001;

  logic [2:0]         state, state_nx;
  logic               aready_r;

  logic               main_valid;
  logic [DATA_W-1:0]  main_data;
  logic [KEEP_W-1:0]  main_keep;
  logic               main_last;
  logic               main_first;
  logic [TUSER_W-1:0] main_tuser;

  logic               skid_valid, skid_valid_nx;
  logic [DATA_W-1:0]  skid_data;
  logic [KEEP_W-1:0]  skid_keep;
  logic               skid_last;
  logic               skid_first;
  logic [TUSER_W-1:0] skid_tuser;

  logic in_xfer, out_xfer, main_load, in_first;

  assign in_xfer   = tin_avalid & aready_r;
  assign out_xfer  = main_valid & tin_bready;
  assign main_load = ~main_valid | out_xfer;
  assign in_first  = (state != BODY);

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (in_xfer & ~tin_atlast) ? BODY : IDLE;
      BODY:    state_nx = (in_xfer & tin_atlast)  ? IDLE : BODY;
      default: state_nx = IDLE;
    endcase
  end

  // Skid only fills while main is held; whenever main can load, the skid
  // (if occupied) empties into it, and ready was already low so no input arrives.
  always_comb begin
    skid_valid_nx = skid_valid;
    if (main_load)
      skid_valid_nx = 1'b0;
    else if (in_xfer)
      skid_valid_nx = 1'b1;
  end

  always_ff @(posedge tin_aclk or negedge tin_arst) begin
    if (!tin_arst) begin
      state      <= IDLE;
      aready_r   <= 1'b0;
      skid_valid <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      state      <= state_nx;
      aready_r   <= ~skid_valid_nx;
      skid_valid <= skid_valid_nx;
      if (out_xfer && main_last)
        pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge tin_aclk or negedge tin_arst) begin
    if (!tin_arst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_keep  <= '0;
      main_last  <= 1'b0;
      main_first <= 1'b0;
      main_tuser <= '0;
    end else if (main_load) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_keep  <= skid_keep;
        main_last  <= skid_last;
        main_first <= skid_first;
        if (skid_first)
          main_tuser <= skid_tuser;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_data  <= tin_adata;
        main_keep  <= tin_akeep;
        main_last  <= tin_atlast;
        main_first <= in_first;
        if (in_first)
          main_tuser <= tin_atuser;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge tin_aclk or negedge tin_arst) begin
    if (!tin_arst) begin
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      skid_first <= 1'b0;
      skid_tuser <= '0;
    end else if (!main_load && in_xfer) begin
      skid_data  <= tin_adata;
      skid_keep  <= tin_akeep;
      skid_last  <= tin_atlast;
      skid_first <= in_first;
      if (in_first)
        skid_tuser <= tin_atuser;
    end
  end

  assign tin_aready = aready_r;
  assign tin_bvalid = main_valid;
  assign tin_bdata  = main_data;
  assign tin_bkeep  = main_keep;
  assign tin_btlast = main_last;
  assign tin_valid  = main_valid & main_first;
  assign tin_data   = main_tuser;
  assign dbg_state  = state;

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Bench for tuser_in_fsm: queue-based reference model of the ingress stage,
// directed scenarios plus randomized traffic with random backpressure.
module tb_tuser_in_fsm;

  localparam int DATA_W  = 256;
  localparam int KEEP_W  = 32;
  localparam int TUSER_W = 128;
  localparam int CNT_W   = 4;

  logic               tin_aclk = 1'b0;
  logic               tin_arst = 1'b0;
  logic               tin_avalid = 1'b0;
  logic               tin_aready;
  logic [DATA_W-1:0]  tin_adata = '0;
  logic [KEEP_W-1:0]  tin_akeep = '0;
  logic               tin_atlast = 1'b0;
  logic [TUSER_W-1:0] tin_atuser = '0;
  logic               tin_bvalid;
  logic               tin_bready = 1'b1;
  logic [DATA_W-1:0]  tin_bdata;
  logic [KEEP_W-1:0]  tin_bkeep;
  logic               tin_btlast;
  logic               tin_valid;
  logic [TUSER_W-1:0] tin_data;
  logic [CNT_W-1:0]   pkt_cnt;
  logic [2:0]         dbg_state;

  tuser_in_fsm #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .TUSER_W(TUSER_W), .CNT_W(CNT_W)) dut (
    .tin_aclk(tin_aclk), .tin_arst(tin_arst),
    .tin_avalid(tin_avalid), .tin_aready(tin_aready), .tin_adata(tin_adata),
    .tin_akeep(tin_akeep), .tin_atlast(tin_atlast), .tin_atuser(tin_atuser),
    .tin_bvalid(tin_bvalid), .tin_bready(tin_bready), .tin_bdata(tin_bdata),
    .tin_bkeep(tin_bkeep), .tin_btlast(tin_btlast),
    .tin_valid(tin_valid), .tin_data(tin_data),
    .pkt_cnt(pkt_cnt), .dbg_state(dbg_state)
  );

  always #5 tin_aclk = ~tin_aclk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats accepted but not yet delivered, in order.
  typedef struct {
    logic [DATA_W-1:0]  d;
    logic [KEEP_W-1:0]  k;
    logic               l;
    logic               f;
    logic [TUSER_W-1:0] u;
  } beat_t;

  beat_t              q[$];
  bit                 in_pkt = 1'b0;
  bit                 m_ar = 1'b0;
  logic [CNT_W-1:0]   m_cnt = '0;
  logic [TUSER_W-1:0] m_tuple = '0;
  bit                 m_in_x, m_out_x;

  always @(posedge tin_aclk or negedge tin_arst) begin
    if (!tin_arst) begin
      q.delete();
      in_pkt = 1'b0;
      m_ar   = 1'b0;
      m_cnt  = '0;
    end else begin
      m_in_x  = tin_avalid && m_ar;
      m_out_x = (q.size() > 0) && tin_bready;
      if (m_out_x) begin
        if (q[0].l) m_cnt = m_cnt + 1'b1;
        void'(q.pop_front());
      end
      if (m_in_x) begin
        q.push_back('{d: tin_adata, k: tin_akeep, l: tin_atlast, f: !in_pkt, u: tin_atuser});
        in_pkt = !tin_atlast;
      end
      // Ready drops only when two beats are held (output slot plus overflow).
      m_ar = (q.size() < 2);
    end
  end

  always @(negedge tin_aclk) begin
    if (!tin_arst)
      m_tuple = '0;
    else if (q.size() > 0 && q[0].f)
      m_tuple = q[0].u;
    chk("aready",    256'(tin_aready), 256'(m_ar));
    chk("bvalid",    256'(tin_bvalid), 256'(q.size() > 0));
    chk("tin_valid", 256'(tin_valid),  256'((q.size() > 0) && q[0].f));
    chk("tin_data",  256'(tin_data),   256'(m_tuple));
    chk("pkt_cnt",   256'(pkt_cnt),    256'(m_cnt));
    chk("dbg_state", 256'(dbg_state),  256'(in_pkt ? 3'd1 : 3'd0));
    if (q.size() > 0) begin
      chk("bdata",  tin_bdata,          q[0].d);
      chk("bkeep",  256'(tin_bkeep),    256'(q[0].k));
      chk("btlast", 256'(tin_btlast),   256'(q[0].l));
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge tin_aclk);
      #1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                      input logic l, input logic [TUSER_W-1:0] u);
    int unsigned n = 0;
    bit done = 1'b0;
    tin_avalid = 1'b1;
    tin_adata  = d;
    tin_akeep  = k;
    tin_atlast = l;
    tin_atuser = u;
    while (!done) begin
      @(negedge tin_aclk);
      done = tin_aready;
      @(posedge tin_aclk);
      #1;
      n++;
      if (!done && n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: aready stuck at %0b, required 1", tin_aready);
        break;
      end
    end
    tin_avalid = 1'b0;
  endtask

  task automatic reset_dut();
    tin_avalid = 1'b0;
    tin_arst   = 1'b0;
    idle(2);
    tin_arst   = 1'b1;
    idle(1);
  endtask

  bit acc;

  initial begin
    idle(3);
    chk("reset_aready", 256'(tin_aready), 256'(0));
    chk("reset_bvalid", 256'(tin_bvalid), 256'(0));
    chk("reset_cnt",    256'(pkt_cnt),    256'(0));
    tin_arst = 1'b1;
    idle(1);
    chk("aready_rise",  256'(tin_aready), 256'(1));

    // Three-beat packet, no backpressure
    send(256'h22222, 32'h33333, 1'b0, 128'h44444);
    send(256'h22223, 32'h33333, 1'b0, 128'h0);
    send(256'h22224, 32'h33333, 1'b1, 128'h0);
    idle(3);
    chk("pkt1_cnt",   256'(pkt_cnt),   256'(1));
    chk("pkt1_tuple", 256'(tin_data),  256'(128'h44444));
    chk("pkt1_state", 256'(dbg_state), 256'(0));

    // Backpressure: two beats accepted, then ready falls and output holds
    reset_dut();
    tin_bready = 1'b0;
    send(256'h100, 32'hF, 1'b0, 128'h77);
    send(256'h101, 32'hF, 1'b0, 128'h0);
    idle(3);
    chk("bp_aready", 256'(tin_aready), 256'(0));
    chk("bp_valid",  256'(tin_valid),  256'(1));
    chk("bp_bdata",  tin_bdata,        256'h100);
    tin_bready = 1'b1;
    send(256'h102, 32'hF, 1'b0, 128'h0);
    send(256'h103, 32'hF, 1'b1, 128'h0);
    idle(3);
    chk("bp_cnt", 256'(pkt_cnt), 256'(1));

    // Back-to-back single-beat packets
    reset_dut();
    send(256'hA1, 32'h1, 1'b1, 128'h1);
    send(256'hA2, 32'h0, 1'b1, 128'h2);
    send(256'hA3, 32'h3, 1'b1, 128'h3);
    idle(3);
    chk("b2b_cnt",   256'(pkt_cnt),  256'(3));
    chk("b2b_tuple", 256'(tin_data), 256'(3));

    // tuser on a non-first beat is ignored
    reset_dut();
    send(256'hB0, 32'hFF, 1'b0, 128'hA);
    send(256'hB1, 32'hFF, 1'b1, 128'hB);
    idle(3);
    chk("nonfirst_tuple", 256'(tin_data), 256'(128'hA));

    // Reset in the middle of a packet
    send(256'hC0, 32'hFF, 1'b0, 128'h99);
    send(256'hC1, 32'hFF, 1'b0, 128'h0);
    reset_dut();
    chk("midrst_bvalid", 256'(tin_bvalid), 256'(0));
    chk("midrst_tuple",  256'(tin_data),   256'(0));
    send(256'hD0, 32'hFF, 1'b1, 128'h55);
    idle(3);
    chk("midrst_new_tuple", 256'(tin_data), 256'(128'h55));
    chk("midrst_cnt",       256'(pkt_cnt),  256'(1));

    // Counter wrap with a 4-bit counter
    reset_dut();
    for (int i = 1; i <= 18; i++) begin
      send(256'(i), 32'h1, 1'b1, 128'(i));
      idle(2);
      if (i == 15) chk("wrap_15", 256'(pkt_cnt), 256'(15));
      if (i == 16) chk("wrap_16", 256'(pkt_cnt), 256'(0));
      if (i == 18) chk("wrap_18", 256'(pkt_cnt), 256'(2));
    end

    // Randomized traffic with random backpressure
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      @(negedge tin_aclk);
      acc = tin_avalid && tin_aready;
      @(posedge tin_aclk);
      #1;
      tin_bready = ($urandom_range(0, 3) != 0);
      if (acc || !tin_avalid) begin
        tin_avalid = ($urandom_range(0, 3) != 0);
        tin_adata  = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        tin_akeep  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
        tin_atlast = ($urandom_range(0, 2) == 0);
        tin_atuser = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    tin_avalid = 1'b0;
    tin_bready = 1'b1;
    idle(5);
    chk("drain_empty", 256'(tin_bvalid), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
